// File: rtl/bcd_count_bank_pkg.sv
// Shared constants and state encoding for the BCD count bank.
package bcd_count_bank_pkg;
    localparam int              BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic {
        IDLE   = 1'b0,
        RIPPLE = 1'b1
    } state_t;
endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit add: digit + inc + carry_in, with decimal carry out.
module bcd_digit_add
    import bcd_count_bank_pkg::*;
(
    input  logic [BCD_W-1:0] digit_in,
    input  logic             inc,
    input  logic             carry_in,
    output logic [BCD_W-1:0] digit_out,
    output logic             carry_out
);
    logic [BCD_W-1:0] sum;

    // Inputs never exceed 9 + 1 + 1, so the sum fits in one nibble.
    assign sum       = digit_in + {{(BCD_W-1){1'b0}}, inc} + {{(BCD_W-1){1'b0}}, carry_in};
    assign carry_out = (sum > BCD_MAX);
    assign digit_out = carry_out ? (sum - (BCD_MAX + 4'd1)) : sum;
endmodule

// File: rtl/bcd_count_bank.sv
// DIGITS-wide BCD counter; per-digit increments applied with a serial
// carry ripple, one digit per clock, and a glitch-free display register.
module bcd_count_bank
    import bcd_count_bank_pkg::*;
#(
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIGITS-1:0]     trigger,
    input  logic                  inc_clk,
    input  logic                  ref_clk,
    output logic [4*DIGITS-1:0]   count_out,
    output logic                  busy,
    output logic                  overflow
);
    localparam int               IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(DIGITS - 1);

    state_t                       state, state_nxt;
    logic [DIGITS-1:0][BCD_W-1:0] work, work_nxt;
    logic [DIGITS-1:0]            mask;
    logic                         carry;
    logic                         ref_pending;
    logic [IDX_W-1:0]             idx;
    logic [BCD_W-1:0]             add_digit;
    logic                         add_carry;
    logic                         last;

    assign last = (idx == LAST);
    assign busy = (state == RIPPLE);

    bcd_digit_add u_add (
        .digit_in  (work[idx]),
        .inc       (mask[idx]),
        .carry_in  (carry),
        .digit_out (add_digit),
        .carry_out (add_carry)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (inc_clk) state_nxt = RIPPLE;
            RIPPLE: if (last)    state_nxt = IDLE;
        endcase
    end

    // Working count after this cycle's digit update; also what the display
    // picks up on the final ripple edge so it never shows a partial result.
    always_comb begin
        work_nxt      = work;
        work_nxt[idx] = add_digit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            work        <= '0;
            mask        <= '0;
            carry       <= 1'b0;
            idx         <= '0;
            ref_pending <= 1'b0;
            count_out   <= '0;
            overflow    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (ref_clk) count_out <= work;
                    if (inc_clk) begin
                        mask  <= trigger;
                        carry <= 1'b0;
                        idx   <= '0;
                    end
                end
                RIPPLE: begin
                    work  <= work_nxt;
                    carry <= add_carry;
                    idx   <= idx + 1'b1;
                    if (ref_clk) ref_pending <= 1'b1;
                    if (last) begin
                        if (add_carry) overflow <= 1'b1;
                        if (ref_pending || ref_clk) count_out <= work_nxt;
                        ref_pending <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_count_bank.sv
// Directed bench for bcd_count_bank: vector table plus multi-cycle corner sequences.
module tb_bcd_count_bank;
    localparam int DIGITS = 6;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [DIGITS-1:0]   trigger = '0;
    logic                inc_clk = 1'b0;
    logic                ref_clk = 1'b0;
    logic [4*DIGITS-1:0] count_out;
    logic                busy;
    logic                overflow;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [DIGITS-1:0]   trig;
        logic [4*DIGITS-1:0] exp_cnt;
        logic                exp_ovf;
    } vec_t;
    vec_t vecs[4];

    bcd_count_bank #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .trigger   (trigger),
        .inc_clk   (inc_clk),
        .ref_clk   (ref_clk),
        .count_out (count_out),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // One increment; waits (bounded) for the ripple to finish.
    task automatic do_inc(input logic [DIGITS-1:0] m, input bit chk_busy);
        int n;
        trigger = m;
        inc_clk = 1'b1;
        tick();
        inc_clk = 1'b0;
        trigger = '0;
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
        if (chk_busy) check("busy_cycles", n, 6);
        else if (n >= 20) check("ripple_timeout", n, 6);
    endtask

    task automatic do_ref();
        ref_clk = 1'b1;
        tick();
        ref_clk = 1'b0;
    endtask

    initial begin
        vecs[0] = '{6'b000001, 24'h000001, 1'b0};
        vecs[1] = '{6'b111111, 24'h111112, 1'b0};
        vecs[2] = '{6'b000000, 24'h111112, 1'b0};
        vecs[3] = '{6'b101010, 24'h212122, 1'b0};

        do_reset();
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        do_ref();
        check("rst_count", count_out, 24'h0);

        // Table: each vector is one inc + ref from the previous state.
        for (int i = 0; i < 4; i++) begin
            do_inc(vecs[i].trig, 1'b1);
            do_ref();
            check("vec_count", count_out, vecs[i].exp_cnt);
            check("vec_ovf", overflow, vecs[i].exp_ovf);
        end

        // Decimal carry from digit 0, then a two-digit increment.
        do_reset();
        for (int i = 0; i < 9; i++) do_inc(6'b000001, 1'b0);
        do_ref();
        check("pre9", count_out, 24'h000009);
        do_inc(6'b000001, 1'b0);
        do_ref();
        check("carry10", count_out, 24'h000010);
        do_inc(6'b000011, 1'b0);
        do_ref();
        check("inc21", count_out, 24'h000021);

        // Full wrap and sticky overflow.
        do_reset();
        for (int i = 0; i < 9; i++) do_inc(6'b111111, 1'b0);
        do_ref();
        check("pre999999", count_out, 24'h999999);
        check("no_ovf_yet", overflow, 0);
        do_inc(6'b000001, 1'b1);
        do_ref();
        check("wrap", count_out, 24'h000000);
        check("ovf_set", overflow, 1);
        for (int i = 0; i < 3; i++) do_inc(6'b000001, 1'b0);
        do_ref();
        check("after_wrap", count_out, 24'h000003);
        check("ovf_sticky", overflow, 1);

        // inc and ref together show the pre-increment value; an inc during
        // the ripple is dropped.
        trigger = 6'b000001;
        inc_clk = 1'b1;
        ref_clk = 1'b1;
        tick();
        inc_clk = 1'b0;
        ref_clk = 1'b0;
        check("same_cycle_ref", count_out, 24'h000003);
        check("same_cycle_busy", busy, 1);
        tick();
        trigger = 6'b000010;
        inc_clk = 1'b1;
        tick();
        inc_clk = 1'b0;
        trigger = '0;
        for (int n = 0; n < 20 && busy; n++) tick();
        check("drop_busy_done", busy, 0);
        do_ref();
        check("inc_dropped", count_out, 24'h000004);

        // ref during ripple is deferred to the ripple's last edge.
        do_reset();
        for (int i = 0; i < 9; i++) do_inc(6'b000011, 1'b0);
        do_ref();
        check("pre99", count_out, 24'h000099);
        trigger = 6'b000001;
        inc_clk = 1'b1;
        tick();
        inc_clk = 1'b0;
        trigger = '0;
        tick();
        ref_clk = 1'b1;
        tick();
        ref_clk = 1'b0;
        begin
            int n;
            n = 0;
            while (busy && n < 20) begin
                check("hold99", count_out, 24'h000099);
                n++;
                tick();
            end
            check("defer_timeout", (n < 20), 1);
        end
        check("defer100", count_out, 24'h000100);

        // Reset mid-ripple discards everything.
        do_reset();
        for (int i = 0; i < 9; i++) do_inc(6'b001111, 1'b0);
        do_ref();
        check("pre9999", count_out, 24'h009999);
        trigger = 6'b000001;
        inc_clk = 1'b1;
        tick();
        inc_clk = 1'b0;
        trigger = '0;
        tick();
        tick();
        tick();
        check("mid_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("midrst_count", count_out, 24'h0);
        check("midrst_busy", busy, 0);
        check("midrst_ovf", overflow, 0);
        tick();
        reset = 1'b0;
        tick();
        do_inc(6'b000001, 1'b1);
        do_ref();
        check("post_rst", count_out, 24'h000001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
